fetch_decode_queue: RTL and testbench
=====================================

# fetch_decode_queue

Parametrised instruction buffer between the fetch and decode stages of the RV32 pipeline. It replaces the single fetch-to-decode pipeline register (instruction, PC, PC+4, branch-predicted-taken) with a DEPTH-entry FIFO. Valid/ready handshakes on both sides let fetch run ahead while decode stalls. A synchronous flush empties the queue on branch mispredict or control transfer.

## Interface
Parameters:
- XLEN, 32, width of PC and PC+4 fields
- ILEN, 32, instruction width
- DEPTH, 4, number of entries; power of two, ≥2

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all entries, same priority as rst
- inValid  in  1  fetch presents an entry
- inReady  out  1  queue can accept; equals !full
- inInstr  in  ILEN  fetched instruction
- inPc  in  XLEN  fetch PC
- inPcPlus4  in  XLEN  fetch PC+4
- inPredTaken  in  1  branch predictor taken flag
- outValid  out  1  head entry valid; equals !empty
- outReady  in  1  decode consumes head; low means decode stall
- outInstr  out  ILEN  head instruction; 0 when outValid=0
- outPc  out  XLEN  head PC; 0 when outValid=0
- outPcPlus4  out  XLEN  head PC+4; 0 when outValid=0
- outPredTaken  out  1  head predicted-taken; 0 when outValid=0
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH

## Operation
- Storage: DEPTH-entry register array. Each entry holds {instr, pc, pcPlus4, predTaken}. Uses write pointer wp and read pointer rp, each $clog2(DEPTH) bits, plus the count register.
- push = inValid & inReady. On push, the entry is written at wp, then wp = wp+1 mod DEPTH.
- pop = outValid & outReady. On pop, rp = rp+1 mod DEPTH.
- count next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- inReady depends only on registered state, never combinationally on outReady. A full queue therefore refuses a push even when a pop occurs in the same cycle.
- Empty queue: outValid=0 and all out data fields read 0. Decode sees a zero bubble, identical to the flushed pipeline register it replaces. outReady is ignored.
- rst or flush: wp=rp=0, count=0. Any push or pop that cycle is discarded. Array contents need not be cleared, because out fields are masked by outValid.
- There is no combinational bypass. An entry pushed into an empty queue appears on out the following cycle.
- Outputs are a mux of the array at rp, gated by outValid. They carry no added combinational dependence on in* signals.

## Timing
- Reset values (cycle after rst high): outValid=0, inReady=1, count=0, empty=1, full=0, all out data 0.
- Latency: push at edge N produces outValid=1 with that entry during cycle N+1.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- After a flush at edge N, outValid=0 in cycle N+1. A push accepted in cycle N+1 appears in N+2.
- Pointer wrap: wp/rp roll from DEPTH−1 to 0 with no gap. FIFO order is preserved across the wrap.
- Flush while stalled (outReady=0) with full queue: inReady=1 and count=0 in the next cycle.

## Test plan
- Reset, then push 3 entries (pc=0x100,0x104,0x108) with outReady=0 → count=3, outPc=0x100 held stable. Then raise outReady for 3 cycles → outPc sequence 0x100,0x104,0x108, then outValid=0 and outInstr=0.
- Fill with DEPTH=4 entries while outReady=0 → full=1, inReady=0. A fifth inValid entry (pc=0x200) is not accepted. Raise outReady for 1 cycle and hold inValid → count returns to 4 and pc=0x200 is present later in order.
- Streaming 10 entries with inValid=outReady=1 continuously → after 1-cycle fill latency, one output per cycle in order. count stays 1 and pointers wrap twice without reordering.
- Queue holds 2 entries, then flush together with inValid (pc=0x300) and outReady → next cycle count=0, outValid=0, and 0x300 is absent. A push of pc=0x400 the cycle after appears one cycle later as the sole entry.
- Push into empty queue (instr=0x00500093, predTaken=1) → the same cycle shows outValid=0. The next cycle shows outInstr=0x00500093 and outPredTaken=1.
- Assert rst mid-stream with count=3 → next cycle all outputs at reset values. The stream then resumes correctly from a fresh push.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of
// {instr, pc, pc+4, predTaken} with valid/ready on both sides and a synchronous flush.
module fetch_decode_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic [ILEN-1:0]              inInstr,
    input  logic [XLEN-1:0]              inPc,
    input  logic [XLEN-1:0]              inPcPlus4,
    input  logic                         inPredTaken,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [ILEN-1:0]              outInstr,
    output logic [XLEN-1:0]              outPc,
    output logic [XLEN-1:0]              outPcPlus4,
    output logic                         outPredTaken,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            pred_taken;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_clear;
    entry_t          w_head;

    // Ready/valid derive only from the registered occupancy, never from the far side
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_clear = rst | flush;
    assign w_push  = inValid & ~w_full;
    assign w_pop   = outReady & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Array is left uncleared on reset; the head is masked by outValid anyway
    always_ff @(posedge clk) begin
        if (w_push && !w_clear) begin
            r_mem[r_wp] <= '{instr: inInstr, pc: inPc, pc_plus4: inPcPlus4,
                             pred_taken: inPredTaken};
        end
    end

    assign w_head       = r_mem[r_rp];
    assign inReady      = ~w_full;
    assign outValid     = ~w_empty;
    assign outInstr     = w_empty ? '0   : w_head.instr;
    assign outPc        = w_empty ? '0   : w_head.pc;
    assign outPcPlus4   = w_empty ? '0   : w_head.pc_plus4;
    assign outPredTaken = w_empty ? 1'b0 : w_head.pred_taken;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized and directed bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pt;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            inValid = 1'b0;
    logic            inReady;
    logic [ILEN-1:0] inInstr = '0;
    logic [XLEN-1:0] inPc = '0;
    logic [XLEN-1:0] inPcPlus4 = '0;
    logic            inPredTaken = 1'b0;
    logic            outValid;
    logic            outReady = 1'b0;
    logic [ILEN-1:0] outInstr;
    logic [XLEN-1:0] outPc;
    logic [XLEN-1:0] outPcPlus4;
    logic            outPredTaken;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t mq[$];

    fetch_decode_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(inReady), .inInstr(inInstr), .inPc(inPc),
        .inPcPlus4(inPcPlus4), .inPredTaken(inPredTaken),
        .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outPc(outPc),
        .outPcPlus4(outPcPlus4), .outPredTaken(outPredTaken),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.instr = $urandom;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.pt    = 1'($urandom_range(0, 1));
        return e;
    endfunction

    // Full output comparison against the model's current contents
    task automatic check_outputs(input string ctx);
        ent_t h;
        int   sz;
        sz = mq.size();
        h  = (sz != 0) ? mq[0] : '0;
        check_eq({ctx, ".outValid"},     64'(outValid),     64'(sz != 0));
        check_eq({ctx, ".inReady"},      64'(inReady),      64'(sz < DEPTH));
        check_eq({ctx, ".count"},        64'(count),        64'(sz));
        check_eq({ctx, ".empty"},        64'(empty),        64'(sz == 0));
        check_eq({ctx, ".full"},         64'(full),         64'(sz == DEPTH));
        check_eq({ctx, ".outInstr"},     64'(outInstr),     64'(h.instr));
        check_eq({ctx, ".outPc"},        64'(outPc),        64'(h.pc));
        check_eq({ctx, ".outPcPlus4"},   64'(outPcPlus4),   64'(h.pc4));
        check_eq({ctx, ".outPredTaken"}, 64'(outPredTaken), 64'(h.pt));
    endtask

    // Drive one cycle from the negedge, advance the model at posedge, check at next negedge
    task automatic cycle(input string ctx, input logic r, input logic f, input logic iv,
                         input logic ordy, input ent_t e);
        bit do_push;
        bit do_pop;
        rst = r; flush = f; inValid = iv; outReady = ordy;
        inInstr = e.instr; inPc = e.pc; inPcPlus4 = e.pc4; inPredTaken = e.pt;
        @(posedge clk);
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        if (r || f) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        @(negedge clk);
        check_outputs(ctx);
    endtask

    initial begin
        ent_t e;
        @(negedge clk);

        // Reset state
        cycle("rst", 1, 0, 0, 0, '0);
        check_eq("rst_inReady", 64'(inReady), 64'd1);
        check_eq("rst_count", 64'(count), 64'd0);

        // Three pushes under stall, then drain in order
        for (int i = 0; i < 3; i++) cycle("p1push", 0, 0, 1, 0, mk(32'h100 + 32'(4*i)));
        check_eq("p1_count3", 64'(count), 64'd3);
        check_eq("p1_head_held", 64'(outPc), 64'h100);
        for (int i = 0; i < 3; i++) begin
            check_eq("p1_pc_seq", 64'(outPc), 64'(32'h100 + 32'(4*i)));
            cycle("p1pop", 0, 0, 0, 1, '0);
        end
        check_eq("p1_drained_valid", 64'(outValid), 64'd0);
        check_eq("p1_drained_instr", 64'(outInstr), 64'd0);

        // Fill to full, fifth entry refused until a pop frees a slot
        for (int i = 0; i < 4; i++) cycle("p2fill", 0, 0, 1, 0, mk(32'h180 + 32'(4*i)));
        check_eq("p2_full", 64'(full), 64'd1);
        check_eq("p2_inReady", 64'(inReady), 64'd0);
        e = mk(32'h200);
        cycle("p2refuse", 0, 0, 1, 0, e);
        check_eq("p2_refused_count", 64'(count), 64'd4);
        cycle("p2pop", 0, 0, 1, 1, e);
        check_eq("p2_after_pop", 64'(count), 64'd3);
        cycle("p2accept", 0, 0, 1, 0, e);
        check_eq("p2_count4", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) cycle("p2drain", 0, 0, 0, 1, '0);

        // Streaming across two pointer wraps
        for (int i = 0; i < 10; i++) begin
            cycle("p3stream", 0, 0, 1, 1, mk(32'h1000 + 32'(4*i)));
            check_eq("p3_count1", 64'(count), 64'd1);
        end
        cycle("p3tail", 0, 0, 0, 1, '0);

        // Flush with pending push and pop
        cycle("p4a", 0, 0, 1, 0, mk(32'h280));
        cycle("p4b", 0, 0, 1, 0, mk(32'h284));
        cycle("p4flush", 0, 1, 1, 1, mk(32'h300));
        check_eq("p4_flush_count", 64'(count), 64'd0);
        check_eq("p4_flush_valid", 64'(outValid), 64'd0);
        cycle("p4push", 0, 0, 1, 0, mk(32'h400));
        check_eq("p4_sole_count", 64'(count), 64'd1);
        check_eq("p4_sole_pc", 64'(outPc), 64'h400);
        cycle("p4drain", 0, 0, 0, 1, '0);

        // No bypass into an empty queue
        e = '{instr: 32'h00500093, pc: 32'h500, pc4: 32'h504, pt: 1'b1};
        check_eq("p5_same_cycle_valid", 64'(outValid), 64'd0);
        cycle("p5push", 0, 0, 1, 0, e);
        check_eq("p5_instr", 64'(outInstr), 64'h00500093);
        check_eq("p5_pt", 64'(outPredTaken), 64'd1);
        cycle("p5drain", 0, 0, 0, 1, '0);

        // Reset mid-stream, then resume
        for (int i = 0; i < 3; i++) cycle("p6fill", 0, 0, 1, 0, mk(32'h600 + 32'(4*i)));
        check_eq("p6_count3", 64'(count), 64'd3);
        cycle("p6rst", 1, 0, 1, 1, mk(32'h700));
        check_eq("p6_rst_count", 64'(count), 64'd0);
        check_eq("p6_rst_pc", 64'(outPc), 64'd0);
        cycle("p6resume", 0, 0, 1, 0, mk(32'h800));
        check_eq("p6_resume_pc", 64'(outPc), 64'h800);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0),
                  mk($urandom & 32'hFFFF_FFFC));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
